// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-fetch stage and the ALU itself.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_NREGS = 32;
  localparam int REG_IDX_W = 5;
  localparam int IMM_W     = 16;

  typedef struct packed {
    logic aOrL;
    logic sOrU;
    logic opCode;
  } alu_ctrl_t;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_e;

  function automatic logic [ALU_WIDTH-1:0] extendImm(input logic [IMM_W-1:0] imm,
                                                     input logic signExt);
    return {{(ALU_WIDTH-IMM_W){signExt & imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_operand_fetch_reg_file.sv
// Two-read, one-write register file with hard-wired zero register and
// same-cycle writeback bypass on both read ports.
module reg_file
  import alu_pkg::*;
#(
  parameter int NREGS = ALU_NREGS,
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [$clog2(NREGS)-1:0] raddrA_i,
  input  logic [$clog2(NREGS)-1:0] raddrB_i,
  output logic [WIDTH-1:0]         rdataA_o,
  output logic [WIDTH-1:0]         rdataB_o,
  input  logic                     wrEn_i,
  input  logic [$clog2(NREGS)-1:0] wrAddr_i,
  input  logic [WIDTH-1:0]         wrData_i
);

  logic [WIDTH-1:0] mem_q [NREGS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wrEn_i && (wrAddr_i != '0)) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  // A writeback landing this cycle is forwarded so dependents issue without a bubble.
  assign rdataA_o = (raddrA_i == '0) ? '0 :
                    (wrEn_i && (wrAddr_i == raddrA_i)) ? wrData_i : mem_q[raddrA_i];
  assign rdataB_o = (raddrB_i == '0) ? '0 :
                    (wrEn_i && (wrAddr_i == raddrB_i)) ? wrData_i : mem_q[raddrB_i];

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage: register read, immediate substitution, RAW scoreboard
// and a single registered output slot feeding the ALU.
module alu_operand_fetch
  import alu_pkg::*;
#(
  parameter int NREGS = ALU_NREGS,
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [$clog2(NREGS)-1:0] Rs,
  input  logic [$clog2(NREGS)-1:0] Rt,
  input  logic [$clog2(NREGS)-1:0] Rd,
  input  logic [IMM_W-1:0]         Imm,
  input  logic                     UseImm,
  input  logic                     A_or_L_In,
  input  logic                     S_or_U_In,
  input  logic                     OpCode_In,
  input  logic                     WbEn,
  input  logic [$clog2(NREGS)-1:0] WbAddr,
  input  logic [WIDTH-1:0]         WbData,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  output logic                     A_or_L,
  output logic                     S_or_U,
  output logic                     OpCode,
  output logic [$clog2(NREGS)-1:0] RdOut
);

  logic [WIDTH-1:0]         rdA, rdB, operandB;
  logic [NREGS-1:0]         pending_q, pending_d;
  logic                     rsHazard, rtHazard, accept;
  slot_state_e              state_q;
  logic [WIDTH-1:0]         a_q, b_q;
  alu_ctrl_t                ctrl_q;
  logic [$clog2(NREGS)-1:0] rd_q;

  reg_file #(.NREGS(NREGS), .WIDTH(WIDTH)) u_regFile (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .raddrA_i (Rs),
    .raddrB_i (Rt),
    .rdataA_o (rdA),
    .rdataB_o (rdB),
    .wrEn_i   (WbEn),
    .wrAddr_i (WbAddr),
    .wrData_i (WbData)
  );

  // A pending source whose producer writes back this very cycle is not a hazard.
  assign rsHazard = (Rs != '0) && pending_q[Rs] && !(WbEn && (WbAddr == Rs));
  assign rtHazard = !UseImm && (Rt != '0) && pending_q[Rt] && !(WbEn && (WbAddr == Rt));
  assign InReady  = !(rsHazard || rtHazard) && (!OutValid || OutReady);
  assign accept   = InValid && InReady;
  assign operandB = UseImm ? WIDTH'(extendImm(Imm, S_or_U_In)) : rdB;

  always_comb begin
    pending_d = pending_q;
    if (WbEn) pending_d[WbAddr] = 1'b0;
    if (accept && (Rd != '0)) pending_d[Rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= SLOT_EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
    end else begin
      if (accept) begin
        a_q    <= rdA;
        b_q    <= operandB;
        ctrl_q <= '{aOrL: A_or_L_In, sOrU: S_or_U_In, opCode: OpCode_In};
        rd_q   <= Rd;
      end
      unique case (state_q)
        SLOT_EMPTY: if (accept) state_q <= SLOT_FULL;
        SLOT_FULL:  if (!accept && OutReady) state_q <= SLOT_EMPTY;
        default:    state_q <= SLOT_EMPTY;
      endcase
    end
  end

  assign OutValid = (state_q == SLOT_FULL);
  assign A        = a_q;
  assign B        = b_q;
  assign A_or_L   = ctrl_q.aOrL;
  assign S_or_U   = ctrl_q.sOrU;
  assign OpCode   = ctrl_q.opCode;
  assign RdOut    = rd_q;

endmodule
